mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/mux_scan_ctrl_settle_counter.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the 4:1 mux scan controller: FSM states, channel index,
// and the settle-counter width.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } scan_state_t;

    typedef logic [1:0] ch_idx_t;

    localparam int unsigned CNT_W   = 4;
    localparam ch_idx_t     CH_LAST = 2'd3;

endpackage

// File: rtl/mux_scan_ctrl_settle_counter.sv
// Per-channel settle timer: counts enabled clocks and pulses tc on the
// clock that completes SETTLE_CYCLES, then restarts from zero.
module settle_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = enable && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux: steps the selects through all four channels,
// waits for the mux to settle on each, and presents the sampled 4-bit word.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start; selects parked at channel a
//   SETTLE | select driven, settle timer running, sample w at terminal count
//   DONE   | data/valid held until the consumer takes the word
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       w,
    input  logic       ready,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy
);

    scan_state_t state, state_nx;
    ch_idx_t     ch;
    logic [2:0]  shadow;
    logic        tc;
    logic        cnt_en;
    logic        cnt_clear;

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Selects only move on a capture edge, so w is sampled after a full settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch     <= '0;
            shadow <= '0;
            data   <= '0;
        end else if (state == SETTLE) begin
            if (abort) begin
                ch <= '0;
            end else if (tc) begin
                if (ch == CH_LAST) begin
                    data <= {w, shadow};
                    ch   <= '0;
                end else begin
                    shadow[ch] <= w;
                    ch         <= ch + 2'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = SETTLE;
            end
            SETTLE: begin
                if (abort)                    state_nx = IDLE;
                else if (tc && ch == CH_LAST) state_nx = DONE;
            end
            DONE: begin
                if (ready) state_nx = start ? SETTLE : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        valid     = 1'b0;
        cnt_en    = 1'b0;
        cnt_clear = 1'b1;
        s0        = ch[0];
        s1        = ch[1];
        if (state == SETTLE) begin
            busy      = 1'b1;
            cnt_en    = !abort;
            cnt_clear = abort;
        end
        if (state == DONE) begin
            valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a behavioural 4:1 mux with a propagation delay
// shorter than the settle time feeds w; completed scans are scoreboarded.
module tb_mux_scan_ctrl;

    localparam int unsigned SETTLE = 3;
    localparam int unsigned MUX_DLY = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b0;
    logic       w;
    logic       s0, s1;
    logic [3:0] data;
    logic       valid, busy;

    logic [3:0]         pattern = 4'b0000;
    logic [MUX_DLY-1:0] pipe = '0;

    int         n_chk = 0;
    int         n_err = 0;
    logic [3:0] sb[$];
    logic [3:0] last_exp = 4'b0000;

    always #5 clk = ~clk;

    // Behavioural mux: selected input reaches w MUX_DLY clocks after the select.
    assign w = pipe[MUX_DLY-1];
    always @(posedge clk) pipe <= {pipe[MUX_DLY-2:0], pattern[{s1, s0}]};

    mux_scan_ctrl #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .w     (w),
        .ready (ready),
        .s0    (s0),
        .s1    (s1),
        .data  (data),
        .valid (valid),
        .busy  (busy)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pop_cmp();
        if (sb.size() == 0) begin
            chk("sb_nonempty", sb.size(), 1);
        end else begin
            last_exp = sb.pop_front();
            chk("data", int'(data), int'(last_exp));
        end
    endtask

    task automatic wait_valid(input int exp_lat);
        int n = 0;
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("valid_seen", int'(valid), 1);
        chk("latency", n, exp_lat);
    endtask

    // Called just after a negedge; returns at the negedge after valid rises.
    task automatic run_scan(input logic [3:0] vals, input bit chk_sel);
        pattern = vals;
        start   = 1'b1;
        sb.push_back(vals);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            chk("busy_scan", int'(busy), 1);
            chk("valid_lo", int'(valid), 0);
            if (chk_sel) chk("sel", int'({s1, s0}), k / 3);
        end
        @(negedge clk);
        chk("valid_hi", int'(valid), 1);
        chk("busy_done", int'(busy), 0);
        chk("sel_done", int'({s1, s0}), 0);
        pop_cmp();
    endtask

    initial begin
        // reset state and no self-start on release
        repeat (3) @(negedge clk);
        chk("rst_out", int'({s1, s0, data, valid, busy}), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_valid", int'(valid), 0);
        chk("post_rst_busy", int'(busy), 0);

        // basic scan with select sequence, immediate handshake
        ready = 1'b1;
        run_scan(4'b1110, 1'b1);
        @(negedge clk);
        chk("hs_valid_lo", int'(valid), 0);

        // held word with back-pressure; start and abort ignored in DONE
        ready = 1'b0;
        run_scan(4'b0001, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) start = 1'b1;
            if (i == 9) start = 1'b0;
            abort = (i == 12);
            chk("hold_valid", int'(valid), 1);
            chk("hold_data", int'(data), int'(last_exp));
        end
        abort = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        chk("bp_valid_lo", int'(valid), 0);
        chk("bp_idle", int'(busy), 0);

        // abort on clock 7 keeps previous data
        pattern = 4'b1010;
        start   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (k == 6) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_sel", int'({s1, s0}), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_data", int'(data), 4'b0001);
        repeat (15) @(negedge clk);
        chk("abort_stay_idle", int'({valid, busy}), 0);

        // back-to-back scans with start held through the handshake
        pattern = 4'b0110;
        start   = 1'b1;
        sb.push_back(4'b0110);
        @(negedge clk);
        wait_valid(12);
        pop_cmp();
        pattern = 4'b1001;
        sb.push_back(4'b1001);
        @(negedge clk);
        chk("b2b_valid_lo", int'(valid), 0);
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_sel", int'({s1, s0}), 0);
        start = 1'b0;
        wait_valid(12);
        pop_cmp();
        @(negedge clk);
        chk("b2b_hs", int'(valid), 0);

        // asynchronous reset during channel c settle
        pattern = 4'b1111;
        start   = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        chk("pre_rst_sel", int'({s1, s0}), 2);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_out", int'({s1, s0, data, valid, busy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_valid", int'({valid, busy}), 0);
        run_scan(4'b0101, 1'b0);
        @(negedge clk);
        chk("final_hs", int'(valid), 0);
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
